// File: rtl/morse_pkg.sv
// Shared types, glyph ROM and helpers for the Morse letter select path.
// Optional reject threshold is enabled with MORSE_THRESH_EN.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUSH
  } state_e;

  localparam int NUM_GLYPHS = 26;

  // {g,f,e,d,c,b,a}, letters a..z
  localparam logic [6:0] SEG_TABLE [0:NUM_GLYPHS-1] = '{
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D,
    7'h76, 7'h06, 7'h1E, 7'h75, 7'h38, 7'h15, 7'h54,
    7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E,
    7'h1C, 7'h2A, 7'h76, 7'h6E, 7'h5B
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Classes beyond the glyph ROM show a blank digit
  function automatic logic [6:0] seg_of(input int i);
    if (i >= 0 && i < NUM_GLYPHS) return SEG_TABLE[i];
    return 7'h00;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Show-ahead synchronous FIFO; head is read straight from storage.
// A push into a full FIFO is accepted only when a pop frees a slot.
module morse_fifo
  import morse_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [CW-1:0]    cnt_q;
  logic             wr;
  logic             rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || pop);
  assign rdata = empty ? '0 : mem_q[rp_q];

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= wdata;
        wp_q        <= wp_q + AW'(1);
      end
      if (rd) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/morse_letter_select.sv
// Multi-cycle argmax over neuron scores feeding a letter/glyph FIFO.
// MORSE_THRESH_EN adds a thresh port and reject entries.
module morse_letter_select
  import morse_pkg::*;
#(
  parameter int NUM_CLASSES = 26,
  parameter int SCORE_W     = 8,
  parameter int LANES       = 1,
  parameter int DEPTH       = 4,
  localparam int LETTER_W   = clog2(NUM_CLASSES + 1),
  localparam int CNT_W      = clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
`ifdef MORSE_THRESH_EN
  input  logic [SCORE_W-1:0]             thresh,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LETTER_W-1:0]            out_letter,
  output logic [6:0]                     out_display,
  output logic                           out_reject,
  output logic [CNT_W-1:0]               fifo_count,
  output logic                           drop_sticky,
  output logic                           ovf_sticky
);

  localparam int PTR_W = clog2(NUM_CLASSES + LANES + 1);
`ifdef MORSE_THRESH_EN
  localparam int FW = LETTER_W + 8;
`else
  localparam int FW = LETTER_W + 7;
`endif

  state_e                         state_q, state_d;
  logic [NUM_CLASSES*SCORE_W-1:0] sc_q, sc_d;
  logic [SCORE_W-1:0]             best_q, best_d;
  logic [LETTER_W-1:0]            idx_q, idx_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic                           drop_q, ovf_q;
  logic                           push;
  logic                           full;
  logic                           empty;
  logic [FW-1:0]                  wdata;
  logic [FW-1:0]                  head;
`ifdef MORSE_THRESH_EN
  logic [SCORE_W-1:0]             thr_q, thr_d;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = !empty;
  assign drop_sticky = drop_q;
  assign ovf_sticky  = ovf_q;

  // Next state and argmax datapath; ties keep the lower index
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    best_d  = best_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
`ifdef MORSE_THRESH_EN
    thr_d   = thr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sc_d    = in_scores;
          best_d  = in_scores[SCORE_W-1:0];
          idx_d   = '0;
          ptr_d   = PTR_W'(1);
          state_d = SCAN;
`ifdef MORSE_THRESH_EN
          thr_d   = thresh;
`endif
        end
      end
      SCAN: begin
        for (int l = 0; l < LANES; l++) begin
          int p;
          p = int'(ptr_q) + l;
          if (p < NUM_CLASSES) begin
            if (sc_q[p*SCORE_W +: SCORE_W] > best_d) begin
              best_d = sc_q[p*SCORE_W +: SCORE_W];
              idx_d  = LETTER_W'(p);
            end
          end
        end
        ptr_d = ptr_q + PTR_W'(LANES);
        if (int'(ptr_q) + LANES >= NUM_CLASSES) state_d = PUSH;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, captured scores and running best
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef MORSE_THRESH_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef MORSE_THRESH_EN
      thr_q   <= thr_d;
`endif
    end
  end

  // Error flags held until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) drop_q <= 1'b1;
      if (push && full && !out_ready) ovf_q <= 1'b1;
    end
  end

`ifdef MORSE_THRESH_EN
  always_comb begin
    wdata = {idx_q, seg_of(int'(idx_q)), 1'b0};
    if (best_q < thr_q)
      wdata = {LETTER_W'(NUM_CLASSES), 7'h00, 1'b1};
  end
  assign {out_letter, out_display, out_reject} = head;
`else
  assign wdata = {idx_q, seg_of(int'(idx_q))};
  assign {out_letter, out_display} = head;
  assign out_reject = 1'b0;
`endif

  morse_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(wdata),
    .pop  (out_ready),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_morse_letter_select.sv
// Directed bench for morse_letter_select (LANES=1 and LANES=5 copies).
// Threshold vectors run only when MORSE_THRESH_EN is defined.
module tb_morse_letter_select;

  localparam int NC = 26;
  localparam int SW = 8;
  localparam int VW = NC * SW;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_valid5;
  logic          in_ready, in_ready5;
  logic [VW-1:0] in_scores;
  logic          out_valid, out_valid5;
  logic          out_ready, out_ready5;
  logic [4:0]    out_letter, out_letter5;
  logic [6:0]    out_display, out_display5;
  logic          out_reject, out_reject5;
  logic [2:0]    fifo_count, fifo_count5;
  logic          drop_sticky, drop_sticky5;
  logic          ovf_sticky, ovf_sticky5;
`ifdef MORSE_THRESH_EN
  logic [SW-1:0] thresh;
`endif

  int checks = 0;
  int errors = 0;

  morse_letter_select #(.LANES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scores(in_scores),
`ifdef MORSE_THRESH_EN
    .thresh(thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_letter(out_letter), .out_display(out_display),
    .out_reject(out_reject), .fifo_count(fifo_count),
    .drop_sticky(drop_sticky), .ovf_sticky(ovf_sticky)
  );

  morse_letter_select #(.LANES(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5),
    .in_scores(in_scores),
`ifdef MORSE_THRESH_EN
    .thresh(thresh),
`endif
    .out_valid(out_valid5), .out_ready(out_ready5),
    .out_letter(out_letter5), .out_display(out_display5),
    .out_reject(out_reject5), .fifo_count(fifo_count5),
    .drop_sticky(drop_sticky5), .ovf_sticky(ovf_sticky5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] sc;
    int            letter;
    int            disp;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input int base, input int k, input int v);
    logic [VW-1:0] s;
    for (int i = 0; i < NC; i++) s[i*SW +: SW] = SW'(base);
    s[k*SW +: SW] = SW'(v);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one vector to an idle DUT and count edges until out_valid
  task automatic send(input bit use5, input logic [VW-1:0] s, output int lat);
    @(negedge clk);
    in_scores = s;
    if (use5) in_valid5 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid5 = 1'b0;
    lat = 1;
    while (!(use5 ? out_valid5 : out_valid) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("idle_wait", int'(in_ready), 1);
  endtask

  // Wait for idle, then present one vector for one edge
  task automatic send_nb(input logic [VW-1:0] s);
    wait_idle();
    in_scores = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop(input bit use5);
    @(negedge clk);
    if (use5) out_ready5 = 1'b1; else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    out_ready5 = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input int exp);
    chk(nm, int'(out_letter), exp);
    pop(1'b0);
  endtask

  initial begin
    int lat;
    logic [VW-1:0] s;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid5  = 1'b0;
    out_ready  = 1'b0;
    out_ready5 = 1'b0;
    in_scores  = '0;
`ifdef MORSE_THRESH_EN
    thresh     = '0;
`endif

    tv[0].sc = fill(1, 7, 200);   tv[0].letter = 7;  tv[0].disp = 'h76;
    s = fill(0, 3, 200);
    s[19*SW +: SW] = 8'd200;
    tv[1].sc = s;                 tv[1].letter = 3;  tv[1].disp = 'h5E;
    tv[2].sc = fill(0, 0, 0);     tv[2].letter = 0;  tv[2].disp = 'h77;
    tv[3].sc = fill(254, 25, 255); tv[3].letter = 25; tv[3].disp = 'h5B;
    tv[4].sc = fill(127, 12, 255); tv[4].letter = 12; tv[4].disp = 'h15;
    for (int i = 0; i < NC; i++) s[i*SW +: SW] = (i <= 19) ? SW'(i * 10) : 8'd0;
    tv[5].sc = s;                 tv[5].letter = 19; tv[5].disp = 'h78;
    tv[6].sc = fill(0, 1, 1);     tv[6].letter = 1;  tv[6].disp = 'h7C;

    do_reset();
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_letter", int'(out_letter), 0);
    chk("rst_display", int'(out_display), 0);
    chk("rst_reject", int'(out_reject), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_drop", int'(drop_sticky), 0);
    chk("rst_ovf", int'(ovf_sticky), 0);

    for (int v = 0; v < 7; v++) begin
      send(1'b0, tv[v].sc, lat);
      chk($sformatf("v%0d_lat", v), lat, 27);
      chk($sformatf("v%0d_letter", v), int'(out_letter), tv[v].letter);
      chk($sformatf("v%0d_disp", v), int'(out_display), tv[v].disp);
      chk($sformatf("v%0d_rej", v), int'(out_reject), 0);
      pop(1'b0);
      chk($sformatf("v%0d_popped", v), int'(out_valid), 0);
      send(1'b1, tv[v].sc, lat);
      chk($sformatf("v%0d_lat5", v), lat, 7);
      chk($sformatf("v%0d_letter5", v), int'(out_letter5), tv[v].letter);
      chk($sformatf("v%0d_disp5", v), int'(out_display5), tv[v].disp);
      pop(1'b1);
      chk($sformatf("v%0d_popped5", v), int'(out_valid5), 0);
    end

    // Back-pressure: fifth result overflows
    do_reset();
    for (int k = 0; k < 5; k++) send_nb(fill(1, k, 9));
    wait_idle();
    chk("bp_count", int'(fifo_count), 4);
    chk("bp_ovf", int'(ovf_sticky), 1);
    chk("bp_drop", int'(drop_sticky), 0);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("bp_pop%0d", k), k);
    chk("bp_empty", int'(out_valid), 0);

    // Full FIFO with a pop in the PUSH cycle
    do_reset();
    for (int k = 0; k < 4; k++) send_nb(fill(1, k, 9));
    wait_idle();
    chk("fp_count_pre", int'(fifo_count), 4);
    send_nb(fill(1, 5, 9));
    repeat (25) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("fp_count", int'(fifo_count), 4);
    chk("fp_ovf", int'(ovf_sticky), 0);
    chk("fp_idle", int'(in_ready), 1);
    pop_chk("fp_pop0", 1);
    pop_chk("fp_pop1", 2);
    pop_chk("fp_pop2", 3);
    pop_chk("fp_pop3", 5);
    chk("fp_empty", int'(out_valid), 0);

    // Busy drop
    do_reset();
    send_nb(fill(1, 7, 9));
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_scores = fill(1, 9, 99);
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bd_drop", int'(drop_sticky), 1);
    wait_idle();
    chk("bd_count", int'(fifo_count), 1);
    chk("bd_letter", int'(out_letter), 7);
    pop(1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("bd_count_end", int'(fifo_count), 0);

    // Reset in the middle of SCAN with one entry already queued
    do_reset();
    send_nb(fill(1, 2, 9));
    send_nb(fill(1, 6, 9));
    repeat (10) @(posedge clk);
    #1;
    chk("ms_busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("ms_in_ready", int'(in_ready), 1);
    chk("ms_out_valid", int'(out_valid), 0);
    chk("ms_letter", int'(out_letter), 0);
    chk("ms_display", int'(out_display), 0);
    chk("ms_count", int'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ms_no_entry", int'(out_valid), 0);

`ifdef MORSE_THRESH_EN
    do_reset();
    thresh = 8'd100;
    send(1'b0, fill(0, 4, 99), lat);
    chk("th_letter", int'(out_letter), 26);
    chk("th_reject", int'(out_reject), 1);
    chk("th_display", int'(out_display), 0);
    pop(1'b0);
    send(1'b0, fill(0, 4, 100), lat);
    chk("th_eq_letter", int'(out_letter), 4);
    chk("th_eq_reject", int'(out_reject), 0);
    chk("th_eq_display", int'(out_display), 'h79);
    pop(1'b0);
    thresh = 8'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
